// File: rtl/sa_tile_seq.sv
// Sequencer for one DIM x DIM systolic matrix-multiply tile: operand row reads, skew/MAC enables, completion.
// Optional busy-cycle counter (perf_cycles/perf_clr) is built when SA_TILE_SEQ_PERF_EN is defined.
module sa_tile_seq #(
  parameter int DIM    = 8,
  parameter int RD_LAT = 1,
  localparam int AW    = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
`ifdef SA_TILE_SEQ_PERF_EN
  input  logic          perf_clr,
  output logic [31:0]   perf_cycles,
`endif
  output logic          busy,
  output logic          done,
  output logic          clr_acc,
  output logic          mem_rd_en,
  output logic [AW-1:0] row_addr,
  output logic          fifo_en,
  output logic          zero_in
);

  localparam int CW = $clog2(2 * DIM + RD_LAT);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(DIM - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * DIM - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          live_fen, live_zin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter restarts from zero on every state entry and counts up to that state's last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = (RD_LAT > 0) ? DRAIN : DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_rd_en = (state_q == LOAD);
  assign clr_acc   = (state_q == LOAD) && (cnt_q == '0);
  assign row_addr  = (state_q == LOAD) ? cnt_q[AW-1:0] : '0;
  assign live_fen  = (state_q == LOAD) || (state_q == FLUSH);
  assign live_zin  = (state_q == FLUSH);

  // Datapath controls lag the state by the memory read latency so they line up with returning rows.
  if (RD_LAT == 0) begin : g_nodly
    assign fifo_en = live_fen;
    assign zero_in = live_zin;
  end else begin : g_dly
    logic [RD_LAT-1:0] fen_q, fen_d, zin_q, zin_d;

    always_comb begin
      fen_d = RD_LAT'({fen_q, live_fen});
      zin_d = RD_LAT'({zin_q, live_zin});
      if (abort && state_q != IDLE) begin
        fen_d = '0;
        zin_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fen_q <= '0;
        zin_q <= '0;
      end else begin
        fen_q <= fen_d;
        zin_q <= zin_d;
      end
    end

    assign fifo_en = fen_q[RD_LAT-1];
    assign zero_in = zin_q[RD_LAT-1];
  end

`ifdef SA_TILE_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (perf_clr) begin
      perf_d = '0;
    end else if (busy && perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sa_tile_seq.sv
// Self-checking bench for sa_tile_seq: a cycle-time reference model pushes expected outputs to a
// scoreboard queue as stimulus is driven; each following negedge pops and compares.
module tb_sa_tile_seq;

   parameter int RD_LAT = 1;
   localparam int DIM = 8;
   localparam int AW = $clog2(DIM);
   localparam int DONE_T = 3 * DIM + RD_LAT;
`ifdef SA_TILE_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic abort;
   logic busy, done, clr_acc, mem_rd_en, fifo_en, zero_in;
   logic [AW-1:0] row_addr;
`ifdef SA_TILE_SEQ_PERF_EN
   logic perf_clr;
   logic [31:0] perf_cycles;
`endif

   int compared = 0;
   int mismatched = 0;
   logic [63:0] expQ[$];
   bit jobActive = 1'b0;
   int jobT = 0;
   logic [31:0] perfModel = '0;

   sa_tile_seq #(.DIM(DIM), .RD_LAT(RD_LAT)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
`ifdef SA_TILE_SEQ_PERF_EN
      .perf_clr(perf_clr),
      .perf_cycles(perf_cycles),
`endif
      .busy(busy),
      .done(done),
      .clr_acc(clr_acc),
      .mem_rd_en(mem_rd_en),
      .row_addr(row_addr),
      .fifo_en(fifo_en),
      .zero_in(zero_in)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Expected outputs derived purely from the cycle offset since the job was accepted.
   function automatic logic [63:0] modelVec();
      logic [63:0] v;
      logic [AW-1:0] row;
      bit b, d, c, m, f, z;
      int t;
      t = jobT;
      b = jobActive;
      d = b && (t == DONE_T);
      c = b && (t == 1);
      m = b && (t >= 1) && (t <= DIM);
      row = m ? AW'(t - 1) : '0;
      f = b && (t >= 1 + RD_LAT) && (t <= 3 * DIM - 1 + RD_LAT);
      z = b && (t >= DIM + 1 + RD_LAT) && (t <= 3 * DIM - 1 + RD_LAT);
      v = '0;
      v[AW+5:0] = {b, d, c, m, row, f, z};
      if (PERF) v[AW+37:AW+6] = perfModel;
      return v;
   endfunction

   // Observed outputs packed in the same layout as the model.
   function automatic logic [63:0] dutVec();
      logic [63:0] v;
      v = '0;
      v[AW+5:0] = {busy, done, clr_acc, mem_rd_en, row_addr, fifo_en, zero_in};
`ifdef SA_TILE_SEQ_PERF_EN
      v[AW+37:AW+6] = perf_cycles;
`endif
      return v;
   endfunction

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      if (obs !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Drives one edge's inputs, advances the model, queues its prediction, then checks the next cycle.
   task automatic applyStimulus(input string tag, input bit s, input bit a, input bit pc);
      start = s;
      abort = a;
`ifdef SA_TILE_SEQ_PERF_EN
      perf_clr = pc;
`endif
      if (pc) perfModel = '0;
      else if (jobActive && perfModel != 32'hFFFF_FFFF) perfModel = perfModel + 32'd1;
      if (jobActive) begin
         if (a) begin
            jobActive = 1'b0;
         end else begin
            jobT++;
            if (jobT > DONE_T) jobActive = 1'b0;
         end
      end else if (s && !a) begin
         jobActive = 1'b1;
         jobT = 1;
      end
      expQ.push_back(modelVec());
      @(negedge clk);
      if (expQ.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s: got empty scoreboard expected a queued entry", tag);
      end else begin
         checkOutput(tag, dutVec(), expQ.pop_front());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
`ifdef SA_TILE_SEQ_PERF_EN
      perf_clr = 1'b0;
`endif
      #1;
      checkOutput("reset", dutVec(), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) applyStimulus("idle", 1'b0, 1'b0, 1'b0);

      // Basic job accepted at edge 0, observed through return to IDLE.
      for (int k = 0; k <= 27; k++) applyStimulus("basic", k == 0, 1'b0, 1'b0);

      // Re-pulsed start while busy and in DONE is ignored; start in IDLE at edge 26 begins a new job.
      for (int k = 0; k <= 56; k++)
         applyStimulus("restart", (k == 0) || (k == 5) || (k == 25) || (k == 26), 1'b0, 1'b0);

      // Abort mid-FLUSH, restart at 14, then abort+start together in IDLE does nothing.
      for (int k = 0; k <= 46; k++)
         applyStimulus("abort", (k == 0) || (k == 14) || (k == 44), (k == 12) || (k == 44), 1'b0);

      // Asynchronous reset between edges during FLUSH.
      for (int k = 0; k <= 14; k++) applyStimulus("midRst", k == 0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRst", dutVec(), 64'd0);
      jobActive = 1'b0;
      jobT = 0;
      perfModel = '0;
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k <= 27; k++) applyStimulus("postRst", k == 0, 1'b0, 1'b0);

      // Busy-cycle accounting: clear, two full jobs, then clear and an aborted job.
      applyStimulus("perfClr", 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= 51; k++)
         applyStimulus("perfJobs", (k == 0) || (k == 26), 1'b0, 1'b0);
`ifdef SA_TILE_SEQ_PERF_EN
      checkOutput("perfTwoJobs", {32'd0, perf_cycles}, 64'd50);
`endif
      applyStimulus("perfClr2", 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= 14; k++)
         applyStimulus("perfAbort", k == 0, k == 12, 1'b0);
`ifdef SA_TILE_SEQ_PERF_EN
      checkOutput("perfAbortCnt", {32'd0, perf_cycles}, 64'd12);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
